data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: MEMORY_DEPTH, default 32, number of 32-bit words in the attached RAM_32.
REQ-002 Parameter: DATA_WIDTH, default 32, data and address width.
REQ-003 Parameter: BASE_ADDR, default 32'h10010000, byte address mapped to RAM word 0.
REQ-004 Reset and clock: one clock, clk; reset is asynchronous and active-low, named reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req_valid_i  input  1  CPU request present.
REQ-008 req_ready_o  output  1  controller can accept a request.
REQ-009 req_we_i  input  1  1 = store, 0 = load.
REQ-010 Address_i  input  DATA_WIDTH  byte address.
REQ-011 Write_Data_i  input  DATA_WIDTH  store data.
REQ-012 rsp_valid_o  output  1  response present.
REQ-013 rsp_ready_i  input  1  CPU accepts the response.
REQ-014 Read_Data_o  output  DATA_WIDTH  load data; 0 for stores and errors.
REQ-015 rsp_err_o  output  1  request rejected (misaligned or out of range).
REQ-016 mem_we_o  output  1  RAM write enable.
REQ-017 mem_addr_o  output  clog2(MEMORY_DEPTH)  RAM word index.
REQ-018 mem_wdata_o  output  DATA_WIDTH  RAM write data.
REQ-019 mem_rdata_i  input  DATA_WIDTH  RAM read data, valid one cycle after mem_addr_o is stable.

Function
REQ-020 The FSM SHALL have the states IDLE, WRITE, READ, READ_WAIT, RESP.
REQ-021 req_ready_o SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid_i=1 in IDLE.
REQ-022 On acceptance, the block SHALL register Address_i, Write_Data_i and req_we_i; later input changes have no effect.
REQ-023 Offset = Address_i - BASE_ADDR (32-bit unsigned, wraps); word index = offset[..:2].
REQ-024 Misaligned (Address_i[1:0] != 0) or offset >= MEMORY_DEPTH*4: go IDLE->RESP with rsp_err_o=1, Read_Data_o=0, no RAM access.
REQ-025 Valid store: IDLE->WRITE; mem_we_o=1 for exactly the one WRITE cycle, with mem_addr_o = index and mem_wdata_o = data; then WRITE->RESP.
REQ-026 Valid load: IDLE->READ (drive mem_addr_o, mem_we_o=0) -> READ_WAIT (capture mem_rdata_i into Read_Data_o at end of cycle) -> RESP.
REQ-027 In RESP, rsp_valid_o=1 and Read_Data_o/rsp_err_o SHALL be held stable until rsp_ready_i=1, then return to IDLE.
REQ-028 Latency from the accepting edge to the first rsp_valid_o cycle: store 2, load 3, error 1 cycle(s); minimum throughput is one request per latency+1 cycles.
REQ-029 mem_we_o SHALL be 0 in every state except WRITE.
REQ-030 mem_addr_o and mem_wdata_o SHALL hold the last registered values outside an access.
REQ-031 A rsp_ready_i=1 outside RESP SHALL be ignored.
REQ-032 A request arriving in the same cycle as rsp_ready_i in RESP SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-033 When reset=0, the block SHALL asynchronously set state=IDLE, and set rsp_valid_o, rsp_err_o, mem_we_o, Read_Data_o, mem_addr_o and mem_wdata_o to 0.
REQ-034 A reset asserted mid-operation SHALL abort the transaction: no response issues, and if in WRITE, mem_we_o drops to 0 immediately.
REQ-035 req_ready_o SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-036 Store 0x10010008 / 0x12345678, rsp_ready_i=1 -> mem_we_o=1 for one cycle with mem_addr_o=2; rsp_valid_o 2 cycles after accept; rsp_err_o=0.
REQ-037 Store 0x1001000C / 0x98761234, then load 0x1001000C -> load has mem_addr_o=3; Read_Data_o=0x98761234 3 cycles after accept.
REQ-038 Store to 0x00000001, then to 0x10010080 -> both give rsp_err_o=1 one cycle after accept; mem_we_o stays 0.
REQ-039 Load 0x10010014 with rsp_ready_i=0 for 5 cycles -> rsp_valid_o and Read_Data_o held stable; req_ready_o=0 until the cycle after rsp_ready_i=1.
REQ-040 Assert reset=0 during WRITE of 0x10010010 / 0xA0A0A0A0 -> mem_we_o=0 at once, no rsp_valid_o, req_ready_o=1 after release.
REQ-041 Back-to-back stores to words 0..31, then reads of all 32 -> all data match; word 31 at 0x1001007C is accepted without error.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// CPU request/response channel plus the RAM_32 port of the data memory controller.
interface data_mem_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 5
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [DATA_WIDTH-1:0] Address_i;
  logic [DATA_WIDTH-1:0] Write_Data_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] Read_Data_o;
  logic                  rsp_err_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, Address_i, Write_Data_i, rsp_ready_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, Read_Data_o, rsp_err_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, Address_i, Write_Data_i, rsp_ready_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, Read_Data_o, rsp_err_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-outstanding load/store controller mapping a byte-address window onto a
// synchronous-read word RAM.
//
// state     | meaning
// IDLE      | ready for a request; decode and register it on acceptance
// WRITE     | one-cycle RAM write strobe
// READ      | RAM address presented, read in flight
// READ_WAIT | RAM data valid, captured at end of cycle
// RESP      | response held until the CPU takes it
module data_mem_ctrl #(
  parameter int                       MEMORY_DEPTH = 32,
  parameter int                       DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]    BASE_ADDR    = 32'h10010000
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_ctrl_if.slave  bus
);
  localparam int AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] LIMIT = DATA_WIDTH'(MEMORY_DEPTH * 4);

  typedef enum logic [2:0] {IDLE, WRITE, READ, READ_WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] offset;
  logic [AW-1:0]         index;
  logic                  req_err;
  logic                  accept;
  logic                  we_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Offset wraps, so addresses below the window land far out of range.
  assign offset  = bus.Address_i - BASE_ADDR;
  assign index   = offset[AW+1:2];
  assign req_err = (bus.Address_i[1:0] != 2'b00) || (offset >= LIMIT);
  assign accept  = (state_q == IDLE) && bus.req_valid_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          if (req_err)           state_d = RESP;
          else if (bus.req_we_i) state_d = WRITE;
          else                   state_d = READ;
        end
      end
      WRITE:     state_d = RESP;
      READ:      state_d = READ_WAIT;
      READ_WAIT: state_d = RESP;
      RESP:      if (bus.rsp_ready_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      read_data_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      if (accept) begin
        we_q        <= bus.req_we_i;
        err_q       <= req_err;
        read_data_q <= '0;
        if (!req_err) begin
          addr_q <= index;
          if (bus.req_we_i) wdata_q <= bus.Write_Data_i;
        end
      end
      if (state_q == READ_WAIT && !we_q) read_data_q <= bus.mem_rdata_i;
    end
  end

  // Strobes decode straight from state so a reset drops them without waiting for a clock.
  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.mem_we_o    = (state_q == WRITE);
  assign bus.rsp_err_o   = err_q;
  assign bus.Read_Data_o = read_data_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
endmodule
